result_collector: RTL
=====================

RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter WIDTH, default 32, sets the data word width in bits.
REQ-002 Parameter DEPTH, default 8, sets words per frame; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  result word from the upstream processor.
REQ-006 in_valid  input  1  in_data holds a valid result word this cycle.
REQ-007 out_data  output  WIDTH  buffered word presented to the consumer.
REQ-008 out_valid  output  1  out_data is valid.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_last  output  1  the presented word is the final word of the frame.
REQ-011 checksum  output  WIDTH  XOR of all DEPTH words of the current frame.
REQ-012 checksum_valid  output  1  checksum is final for the frame being drained.
REQ-013 busy  output  1  state is not IDLE.
REQ-014 overrun  output  1  sticky flag: a word was dropped.

Function
REQ-015 The FSM SHALL have three states: IDLE, FILL and DRAIN.
REQ-016 In IDLE with in_valid=1, the block SHALL write in_data to buf[0], set wr_cnt=1, load checksum=in_data and go to FILL.
REQ-017 In FILL, each cycle with in_valid=1 SHALL write buf[wr_cnt], increment wr_cnt and XOR in_data into checksum.
REQ-018 In FILL, cycles with in_valid=0 SHALL hold all state; gaps of any length are legal.
REQ-019 When the DEPTH-th word is written, the FSM SHALL go to DRAIN with rd_ptr=0; out_valid SHALL rise the next cycle (one-cycle latency).
REQ-020 In DRAIN, out_valid=1, out_data=buf[rd_ptr], checksum_valid=1, and out_last=1 exactly when rd_ptr=DEPTH-1.
REQ-021 A transfer SHALL occur only when out_valid=1 and out_ready=1; rd_ptr then increments. Without a transfer, out_data and out_last SHALL stay stable.
REQ-022 On the transfer with out_last=1, the FSM SHALL leave DRAIN: to IDLE if in_valid=0, or to FILL if in_valid=1.
REQ-023 When leaving DRAIN with in_valid=1, in_data SHALL be captured as word 0 of the next frame (checksum reloaded, wr_cnt=1); this is not an overrun.
REQ-024 In any other DRAIN cycle, a word with in_valid=1 SHALL be discarded, and overrun SHALL be set to 1 and held until reset.
REQ-025 checksum_valid SHALL fall when the FSM leaves DRAIN; checksum SHALL hold its value until the next frame's first word is captured.
REQ-026 wr_cnt and rd_ptr SHALL be log2(DEPTH) bits wide and SHALL never wrap within a frame.
REQ-027 busy SHALL be 1 in FILL and DRAIN and 0 in IDLE.

Reset
REQ-028 Assertion of reset SHALL immediately force state=IDLE and all of these to 0: wr_cnt, rd_ptr, checksum, out_valid, out_last, checksum_valid, busy, overrun.
REQ-029 Reset in the middle of FILL or DRAIN SHALL abandon the partial frame; the next in_valid after release SHALL start a new frame at buf[0].
REQ-030 Buffer contents need not be cleared by reset; out_data is don't-care while out_valid=0.

Verification
REQ-031 Basic frame: in_data = 1..8 on 8 consecutive in_valid cycles, out_ready=1 -> one cycle after the 8th word, out_valid=1, out_data = 1..8 on consecutive cycles, out_last=1 only on value 8, checksum=0x00000008, checksum_valid=1 throughout.
REQ-032 Gapped input: the same 8 words with in_valid low every other cycle -> identical output order and checksum; out_valid stays 0 until the 8th word.
REQ-033 Backpressure: out_ready toggling 1,0,0,1,... -> each word is held stable while stalled, no word lost or duplicated, exactly 8 transfers.
REQ-034 Overrun: in_valid=1 with 0xDEADBEEF during the 3rd drain cycle -> word not emitted, overrun=1 and stays 1, current frame output unchanged.
REQ-035 Back-to-back frames: in_valid=1 with 0xA5A5A5A5 on the last-transfer cycle -> no overrun, FSM goes to FILL with wr_cnt=1, next frame begins with 0xA5A5A5A5.
REQ-036 Mid-frame reset: reset pulsed after 5 words in FILL -> all outputs 0 immediately; a following 8-word frame 0x10..0x17 drains correctly with checksum=0x00000000.

Source files
------------

// File: rtl/result_collector.sv
// result_collector: gathers DEPTH result words into a frame buffer while
// XOR-accumulating a checksum, then drains the frame to a valid/ready
// consumer. Words that arrive while draining are dropped and flagged,
// except on the final transfer, where the word opens the next frame.
module result_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [WIDTH-1:0] checksum,
    output logic             checksum_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state;
    logic [AW-1:0]    wr_cnt;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] buf_mem [DEPTH];

    logic             xfer;
    logic             frame_done;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    // out_valid is only ever high in DRAIN, so a transfer of the last word
    // is exactly the frame-complete event.
    assign xfer       = out_valid & out_ready;
    assign frame_done = xfer & out_last;

    // Buffer write port: word 0 on frame start (from IDLE or on the final
    // drain transfer), word wr_cnt while filling.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        unique case (state)
            IDLE: begin
                wr_en = in_valid;
            end
            FILL: begin
                wr_en   = in_valid;
                wr_addr = wr_cnt;
            end
            DRAIN: begin
                wr_en = in_valid & frame_done;
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
    end

    // Frame storage is data only and is left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= in_data;
        end
    end

    // rd_ptr only moves on a transfer, so the presented word holds while stalled.
    assign out_data = buf_mem[rd_ptr];

    // Control FSM with registered status outputs and running checksum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wr_cnt         <= '0;
            rd_ptr         <= '0;
            checksum       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            checksum_valid <= 1'b0;
            busy           <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        wr_cnt   <= ONE;
                        checksum <= in_data;
                        busy     <= 1'b1;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        checksum <= checksum ^ in_data;
                        if (wr_cnt == LAST_IDX) begin
                            wr_cnt         <= '0;
                            rd_ptr         <= '0;
                            out_valid      <= 1'b1;
                            out_last       <= 1'b0;
                            checksum_valid <= 1'b1;
                            state          <= DRAIN;
                        end else begin
                            wr_cnt <= wr_cnt + ONE;
                        end
                    end
                end
                DRAIN: begin
                    if (xfer) begin
                        if (out_last) begin
                            out_valid      <= 1'b0;
                            out_last       <= 1'b0;
                            checksum_valid <= 1'b0;
                            rd_ptr         <= '0;
                            if (in_valid) begin
                                wr_cnt   <= ONE;
                                checksum <= in_data;
                                state    <= FILL;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            rd_ptr   <= rd_ptr + ONE;
                            out_last <= ((rd_ptr + ONE) == LAST_IDX);
                        end
                    end
                    // Any word arriving mid-drain has nowhere to go.
                    if (in_valid && !frame_done) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
